// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared types and helpers for the ALU arbiter. Holds the
//               arbiter state encoding, the ALU op-code constants and the
//               qualifiers that say which ops produce a meaningful carry/
//               shift-out word or branch-taken flag.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned OP_AND     = 0;
    localparam int unsigned OP_OR      = 1;
    localparam int unsigned OP_ADD     = 2;
    localparam int unsigned OP_SUB     = 3;
    localparam int unsigned OP_SHL     = 4;
    localparam int unsigned OP_BEQ     = 5;
    localparam int unsigned OP_MEM     = 6;
    localparam int unsigned OP_ILLEGAL = 7;

    // The alu leaves car_out stale for ops that do not produce one.
    function automatic logic car_valid(input logic [31:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
    endfunction

    function automatic logic jump_valid(input logic [31:0] op);
        return (op == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               starting one position after ptr (wrapping) and returns the
//               first set request as a one-hot grant plus its index.
// Ports       : req   [N-1:0]  request vector
//               ptr   [IW-1:0] last granted index
//               grant [N-1:0]  one-hot grant (all 0 when no request)
//               idx   [IW-1:0] index of the granted request
//               any            at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] w_cand;

    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((32'(ptr) + 32'(k)) % 32'(N));
            if (!any && req[w_cand]) begin
                any           = 1'b1;
                grant[w_cand] = 1'b1;
                idx           = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational alu between NUM_REQ requesters.
//               Round-robin grant, operand capture, one alu cycle, then a
//               registered response held until the consumer accepts it.
//               The alu only ever sees registered operands.
// Ports       : clk, rst_n                 clock, async active-low reset
//               req_valid/req_ready        per-requester handshake
//               req_op/req_ra/req_rb       packed per-requester operands
//               resp_valid/resp_ready      one-hot response handshake
//               resp_res/car/zero/jump/err response payload
//               alu_ra/alu_rb/alu_op       drive the shared alu
//               alu_res/car/zero/jump      results from the shared alu
//               grant_cnt                  (ALU_ARB_PERF_EN only) 16-bit
//                                          saturating grant count per req
// Config      : `define ALU_ARB_PERF_EN to add the grant_cnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int reg_width = 8,
    parameter int op_width  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*op_width-1:0]   req_op,
    input  logic [NUM_REQ*reg_width-1:0]  req_ra,
    input  logic [NUM_REQ*reg_width-1:0]  req_rb,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic                          resp_ready,
    output logic [reg_width-1:0]          resp_res,
    output logic [reg_width-1:0]          resp_car,
    output logic                          resp_zero,
    output logic                          resp_jump,
    output logic                          resp_err,
    output logic [reg_width-1:0]          alu_ra,
    output logic [reg_width-1:0]          alu_rb,
    output logic [op_width-1:0]           alu_op,
    input  logic [reg_width-1:0]          alu_res,
    input  logic [reg_width-1:0]          alu_car,
    input  logic                          alu_zero,
    input  logic                          alu_jump
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_ptr;
    logic [op_width-1:0]  r_op;
    logic [reg_width-1:0] r_ra;
    logic [reg_width-1:0] r_rb;
    logic [NUM_REQ-1:0]   r_gnt;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_arb_en;
    logic                 w_xfer;
    logic                 w_ill;
    logic [reg_width-1:0] w_res;
    logic [reg_width-1:0] w_car;
    logic                 w_jump;

    // Zero is recomputed from the masked result, so the alu's flag is not needed.
    logic w_unused;
    assign w_unused = alu_zero;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // Arbitration is open when idle, or in the cycle a response is accepted.
    assign w_arb_en  = (r_state == ST_IDLE) || ((r_state == ST_RESP) && resp_ready);
    assign req_ready = w_arb_en ? w_grant : '0;
    assign w_xfer    = w_arb_en && w_any;

    assign w_ill  = (r_op == op_width'(OP_ILLEGAL));
    assign w_res  = w_ill ? '0 : alu_res;
    assign w_car  = (!w_ill && car_valid(32'(r_op))) ? alu_car : '0;
    assign w_jump = jump_valid(32'(r_op)) && alu_jump;

    // An illegal op never reaches the alu; it keeps the benign pass-through op.
    always_comb begin
        alu_op = op_width'(OP_MEM);
        alu_ra = '0;
        alu_rb = '0;
        if ((r_state == ST_EXEC) && !w_ill) begin
            alu_op = r_op;
            alu_ra = r_ra;
            alu_rb = r_rb;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (resp_ready) w_next = w_xfer ? ST_EXEC : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_op       <= '0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_gnt      <= '0;
            resp_valid <= '0;
            resp_res   <= '0;
            resp_car   <= '0;
            resp_zero  <= 1'b0;
            resp_jump  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_op  <= req_op[w_idx*op_width +: op_width];
                r_ra  <= req_ra[w_idx*reg_width +: reg_width];
                r_rb  <= req_rb[w_idx*reg_width +: reg_width];
                r_gnt <= w_grant;
                r_ptr <= w_idx;
            end
            if (r_state == ST_EXEC) begin
                resp_valid <= r_gnt;
                resp_res   <= w_res;
                resp_car   <= w_car;
                resp_zero  <= (w_res == '0);
                resp_jump  <= w_jump;
                resp_err   <= w_ill;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                resp_valid <= '0;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_cnt [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[gi] <= '0;
            end else if (req_valid[gi] && req_ready[gi] && (r_cnt[gi] != 16'hFFFF)) begin
                r_cnt[gi] <= r_cnt[gi] + 16'd1;
            end
        end
        assign grant_cnt[gi*16 +: 16] = r_cnt[gi];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter (NUM_REQ=2, 8-bit data).
//               Provides a behavioural alu, a transaction-level model of
//               the arbiter (one op in flight, response visible two cycles
//               after the request cycle, round-robin order) and directed
//               plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [5:0]   req_op;
    logic [15:0]  req_ra;
    logic [15:0]  req_rb;
    logic [1:0]   resp_valid;
    logic         resp_ready;
    logic [7:0]   resp_res;
    logic [7:0]   resp_car;
    logic         resp_zero;
    logic         resp_jump;
    logic         resp_err;
    logic [7:0]   alu_ra;
    logic [7:0]   alu_rb;
    logic [2:0]   alu_op;
    logic [7:0]   alu_res;
    logic [7:0]   alu_car;
    logic         alu_zero;
    logic         alu_jump;

    alu_arbiter #(.NUM_REQ(2), .reg_width(8), .op_width(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_ra     (req_ra),
        .req_rb     (req_rb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res),
        .resp_car   (resp_car),
        .resp_zero  (resp_zero),
        .resp_jump  (resp_jump),
        .resp_err   (resp_err),
        .alu_ra     (alu_ra),
        .alu_rb     (alu_rb),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_car    (alu_car),
        .alu_zero   (alu_zero),
        .alu_jump   (alu_jump)
    );

    always #5 clk = ~clk;

    // Behavioural alu. Non-carry ops leave a junk carry word (0xA5) and
    // non-branch ops a junk jump flag, so the arbiter's masking is exercised.
    function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] w;
        logic [7:0]  r;
        logic [7:0]  c;
        logic        j;
        r = 8'h00; c = 8'hA5; j = 1'b1; s = '0; w = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = {7'b0, s[8]}; end
            3'd3: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = {7'b0, s[8]}; end
            3'd4: begin w = {8'h00, a} << b[2:0]; r = w[7:0]; c = w[15:8]; end
            3'd5: begin r = a - b; j = (a == b); end
            3'd6: r = a;
            default: r = 8'hEE;
        endcase
        return {j, c, r};
    endfunction

    always_comb begin
        {alu_jump, alu_car, alu_res} = alu_f(alu_op, alu_ra, alu_rb);
        alu_zero = (alu_res == 8'h00);
    end

    int errors = 0;
    int checks = 0;
    int t = 0;

    // Reference model state
    bit         m_pend;
    int         m_vis;
    int         m_id;
    int         m_ptr;
    logic [2:0] m_op;
    logic [7:0] m_ra, m_rb;
    logic [7:0] e_res, e_car;
    bit         e_zero, e_jump, e_err;

    // Observation log
    int         gq[$];
    int         n_resp = 0;
    logic [1:0] lo_valid;
    logic [7:0] lo_res, lo_car;
    logic       lo_zero, lo_jump, lo_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid[i]        = v;
        req_op[i*3 +: 3]    = op;
        req_ra[i*8 +: 8]    = a;
        req_rb[i*8 +: 8]    = b;
    endtask

    // One clock cycle: check outputs against the model mid-cycle, advance the model.
    task automatic cycle();
        logic [1:0]  eg;
        int          gid;
        bit          vis;
        bit          free;
        logic [16:0] raw;
        @(negedge clk);
        vis = m_pend && (t >= m_vis);
        chk("resp_valid", 32'(resp_valid), vis ? 32'(1 << m_id) : 32'd0);
        if (vis) begin
            chk("resp_res",  32'(resp_res),  32'(e_res));
            chk("resp_car",  32'(resp_car),  32'(e_car));
            chk("resp_zero", 32'(resp_zero), 32'(e_zero));
            chk("resp_jump", 32'(resp_jump), 32'(e_jump));
            chk("resp_err",  32'(resp_err),  32'(e_err));
        end
        if (m_pend && (t == m_vis - 1) && (m_op != 3'd7)) begin
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_ra", 32'(alu_ra), 32'(m_ra));
            chk("alu_rb", 32'(alu_rb), 32'(m_rb));
        end else begin
            chk("alu_op_idle", 32'(alu_op), 32'd6);
            chk("alu_ra_idle", 32'(alu_ra), 32'd0);
            chk("alu_rb_idle", 32'(alu_rb), 32'd0);
        end
        if (resp_valid != 2'b00) begin
            n_resp++;
            lo_valid = resp_valid; lo_res = resp_res; lo_car = resp_car;
            lo_zero = resp_zero;   lo_jump = resp_jump; lo_err = resp_err;
        end
        free = !m_pend || (vis && resp_ready);
        eg   = 2'b00;
        gid  = -1;
        if (free) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (gid < 0 && req_valid[c]) begin
                    gid   = c;
                    eg[c] = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (vis && resp_ready) m_pend = 0;
        if (gid >= 0) begin
            gq.push_back(gid);
            m_pend = 1;
            m_vis  = t + 2;
            m_id   = gid;
            m_ptr  = gid;
            m_op   = req_op[gid*3 +: 3];
            m_ra   = req_ra[gid*8 +: 8];
            m_rb   = req_rb[gid*8 +: 8];
            raw    = alu_f(m_op, m_ra, m_rb);
            e_res  = (m_op == 3'd7) ? 8'h00 : raw[7:0];
            e_car  = (m_op == 3'd2 || m_op == 3'd3 || m_op == 3'd4) ? raw[15:8] : 8'h00;
            e_jump = (m_op == 3'd5) ? raw[16] : 1'b0;
            e_zero = (e_res == 8'h00);
            e_err  = (m_op == 3'd7);
        end
        @(posedge clk);
        t++;
        #1;
    endtask

    // Single op from an idle arbiter: request cycle, alu cycle, response cycle.
    task automatic one_op(input int i, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
        resp_ready = 1'b1;
        set_req(i, 1'b1, op, a, b);
        cycle();
        req_valid = 2'b00;
        cycle();
        cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
        chk({tag, "_resp_res"},   32'(resp_res),   32'd0);
        chk({tag, "_resp_car"},   32'(resp_car),   32'd0);
        chk({tag, "_flags"},      32'({resp_zero, resp_jump, resp_err}), 32'd0);
        chk({tag, "_alu_op"},     32'(alu_op),     32'd6);
        chk({tag, "_alu_ops"},    32'({alu_ra, alu_rb}), 32'd0);
    endtask

    initial begin
        int g0, r0;
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_ra = '0; req_rb = '0; resp_ready = 1'b0;
        m_pend = 0; m_ptr = N - 1; m_vis = 0; m_id = 0;
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single add from req0
        one_op(0, 3'd2, 8'd100, 8'd27);
        chk("t1_valid", 32'(lo_valid), 32'h1);
        chk("t1_res",   32'(lo_res),   32'd127);
        chk("t1_car",   32'(lo_car),   32'd0);

        // 2: contention, both valid, consumer always ready
        resp_ready = 1'b1;
        set_req(0, 1'b1, 3'd1, 8'h12, 8'h34);
        set_req(1, 1'b1, 3'd2, 8'hF0, 8'h20);
        g0 = gq.size();
        repeat (8) cycle();
        chk("t2_grants", 32'(gq.size() - g0), 32'd4);
        chk("t2_first",  32'(gq[g0]), 32'd1);
        for (int i = 1; i < 4; i++) chk("t2_alt", 32'(gq[g0+i] != gq[g0+i-1]), 32'd1);

        // 3: backpressure for 5 cycles while both keep requesting
        resp_ready = 1'b0;
        g0 = gq.size(); r0 = n_resp;
        repeat (5) cycle();
        chk("t3_no_grant", 32'(gq.size() - g0), 32'd0);
        chk("t3_held",     32'(n_resp - r0),    32'd5);
        resp_ready = 1'b1;
        cycle();
        chk("t3_release_grant", 32'(gq.size() - g0), 32'd1);
        req_valid = 2'b00;
        repeat (3) cycle();

        // 4: masking
        one_op(0, 3'd3, 8'h05, 8'h09);
        chk("t4_sub_car", 32'(lo_car), 32'd1);
        one_op(0, 3'd0, 8'h0F, 8'hF0);
        chk("t4_and_res",  32'(lo_res),  32'd0);
        chk("t4_and_zero", 32'(lo_zero), 32'd1);
        chk("t4_and_car",  32'(lo_car),  32'd0);
        chk("t4_and_jump", 32'(lo_jump), 32'd0);
        one_op(0, 3'd5, 8'd1, 8'd1);
        chk("t4_beq_jump", 32'(lo_jump), 32'd1);

        // 5: illegal op from req1
        one_op(1, 3'd7, 8'h55, 8'h22);
        chk("t5_valid", 32'(lo_valid), 32'h2);
        chk("t5_err",   32'(lo_err),   32'd1);
        chk("t5_res",   32'(lo_res),   32'd0);
        chk("t5_zero",  32'(lo_zero),  32'd1);

        // 6: reset while the op is in the alu cycle
        resp_ready = 1'b1;
        set_req(0, 1'b1, 3'd2, 8'd3, 8'd4);
        cycle();
        rst_n = 1'b0;
        req_valid = 2'b00;
        m_pend = 0; m_ptr = N - 1;
        #1;
        chk_all_zero("t6_async");
        @(negedge clk);
        chk_all_zero("t6_next");
        rst_n = 1'b1;
        @(posedge clk); t++; #1;
        r0 = n_resp;
        repeat (4) cycle();
        chk("t6_no_resp", 32'(n_resp - r0), 32'd0);
        set_req(0, 1'b1, 3'd6, 8'h11, 8'h00);
        set_req(1, 1'b1, 3'd6, 8'h22, 8'h00);
        g0 = gq.size();
        cycle();
        chk("t6_first_grant", 32'(gq[g0]), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++)
                set_req(r, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
